// File: rtl/pll_sup_pkg.sv
// Shared state encoding and sizing helper for the PLL lock supervisor.
package pll_sup_pkg;

  localparam int SUP_STATE_W = 3;

  typedef enum logic [SUP_STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } sup_state_e;

  // Bits needed for a counter that runs 0..tc-1.
  function automatic int cnt_width(input int tc);
    return (tc > 1) ? $clog2(tc) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the raw PLL locked flag into the refclk domain.
module pll_lock_sync (
  input  logic refclk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: PLL reset pulse, lock qualification, staged domain reset release.
// Optional lock-loss counter built only when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CLKS            = 4,
  parameter int RST_PULSE           = 8,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP         = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked_async,
  input  logic                   clr_cnt,
  output logic                   pll_rst,
  output logic [NUM_CLKS-1:0]    chan_rst_n,
  output logic                   all_ready,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       lock_loss_cnt,
  output logic [SUP_STATE_W-1:0] sup_state
);

  // One counter serves both the reset pulse and the lock timeout.
  localparam int PT_TC  = (RST_PULSE > LOCK_TIMEOUT_CYCLES) ? RST_PULSE : LOCK_TIMEOUT_CYCLES;
  localparam int PT_W   = cnt_width(PT_TC);
  localparam int ST_W   = cnt_width(LOCK_STABLE_CYCLES);
  localparam int REL_TC = NUM_CLKS * RELEASE_GAP;
  localparam int REL_W  = cnt_width(REL_TC);

  localparam logic [PT_W-1:0]  RST_LAST  = PT_W'(RST_PULSE - 1);
  localparam logic [PT_W-1:0]  TO_LAST   = PT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0]  STAB_LAST = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST  = REL_W'(REL_TC - 1);

  logic locked_s;

  pll_lock_sync u_sync (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .async_in (pll_locked_async),
    .sync_out (locked_s)
  );

  sup_state_e            state_reg, state_next;
  logic [PT_W-1:0]       pt_cnt_reg, pt_cnt_next;
  logic [ST_W-1:0]       stab_cnt_reg, stab_cnt_next;
  logic [REL_W-1:0]      rel_cnt_reg, rel_cnt_next;
  logic                  pll_rst_reg, pll_rst_next;
  logic [NUM_CLKS-1:0]   chan_reg, chan_next;
  logic                  ready_reg, ready_next;
  logic                  to_reg, to_next;
  logic                  loss_evt;
  logic [NUM_CLKS-1:0]   rel_hit;

  // Bit gi of the release vector comes due as rel_cnt steps onto gi*RELEASE_GAP.
  assign rel_hit[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_CLKS; gi++) begin : g_rel_hit
    assign rel_hit[gi] = (rel_cnt_reg == REL_W'(gi * RELEASE_GAP - 1));
  end

  always_comb begin
    state_next    = state_reg;
    pt_cnt_next   = pt_cnt_reg;
    stab_cnt_next = stab_cnt_reg;
    rel_cnt_next  = rel_cnt_reg;
    pll_rst_next  = pll_rst_reg;
    chan_next     = chan_reg;
    ready_next    = 1'b0;
    to_next       = 1'b0;
    loss_evt      = 1'b0;

    case (state_reg)
      ST_PLL_RST: begin
        pll_rst_next = 1'b1;
        chan_next    = '0;
        if (pt_cnt_reg == RST_LAST) begin
          state_next   = ST_WAIT_LOCK;
          pt_cnt_next  = '0;
          pll_rst_next = 1'b0;
        end else begin
          pt_cnt_next = pt_cnt_reg + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        pll_rst_next = 1'b0;
        chan_next    = '0;
        if (locked_s) begin
          state_next    = ST_STABLE;
          stab_cnt_next = '0;
        end else if (pt_cnt_reg == TO_LAST) begin
          state_next   = ST_PLL_RST;
          pt_cnt_next  = '0;
          pll_rst_next = 1'b1;
          to_next      = 1'b1;
        end else begin
          pt_cnt_next = pt_cnt_reg + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          // A dropout before release is a retry, not a counted loss.
          state_next  = ST_WAIT_LOCK;
          pt_cnt_next = '0;
        end else if (stab_cnt_reg == STAB_LAST) begin
          state_next   = ST_RELEASE;
          rel_cnt_next = '0;
          chan_next    = NUM_CLKS'(1);
        end else begin
          stab_cnt_next = stab_cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          loss_evt = 1'b1;
        end else if (rel_cnt_reg == REL_LAST) begin
          state_next = ST_RUN;
          ready_next = 1'b1;
        end else begin
          rel_cnt_next = rel_cnt_reg + 1'b1;
          chan_next    = chan_reg | rel_hit;
        end
      end
      ST_RUN: begin
        if (!locked_s) loss_evt = 1'b1;
        else           ready_next = 1'b1;
      end
      default: begin
        state_next   = ST_PLL_RST;
        pt_cnt_next  = '0;
        pll_rst_next = 1'b1;
        chan_next    = '0;
      end
    endcase

    if (loss_evt) begin
      state_next   = ST_PLL_RST;
      pt_cnt_next  = '0;
      pll_rst_next = 1'b1;
      chan_next    = '0;
      ready_next   = 1'b0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_PLL_RST;
      pt_cnt_reg   <= '0;
      stab_cnt_reg <= '0;
      rel_cnt_reg  <= '0;
      pll_rst_reg  <= 1'b1;
      chan_reg     <= '0;
      ready_reg    <= 1'b0;
      to_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pt_cnt_reg   <= pt_cnt_next;
      stab_cnt_reg <= stab_cnt_next;
      rel_cnt_reg  <= rel_cnt_next;
      pll_rst_reg  <= pll_rst_next;
      chan_reg     <= chan_next;
      ready_reg    <= ready_next;
      to_reg       <= to_next;
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_reg;

  // Clear takes precedence, but a loss in the same cycle still registers as one.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_reg <= '0;
    end else if (clr_cnt) begin
      loss_cnt_reg <= loss_evt ? CNT_W'(1) : '0;
    end else if (loss_evt && (loss_cnt_reg != '1)) begin
      loss_cnt_reg <= loss_cnt_reg + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt_reg;
`else
  logic unused_loss;
  assign unused_loss   = loss_evt ^ clr_cnt;
  assign lock_loss_cnt = '0;
`endif

  assign pll_rst     = pll_rst_reg;
  assign chan_rst_n  = chan_reg;
  assign all_ready   = ready_reg;
  assign timeout_err = to_reg;
  assign sup_state   = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed, table-driven bench for pll_lock_supervisor using the small test-plan parameters.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked_async;
  logic       clr_cnt;
  logic       pll_rst;
  logic [3:0] chan_rst_n;
  logic       all_ready;
  logic       timeout_err;
  logic [1:0] lock_loss_cnt;
  logic [2:0] sup_state;

  int tests = 0;
  int fails = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .NUM_CLKS(4), .RST_PULSE(8), .LOCK_STABLE_CYCLES(16),
    .RELEASE_GAP(4), .LOCK_TIMEOUT_CYCLES(64), .CNT_W(2)
  ) dut (
    .refclk           (refclk),
    .rst_n            (rst_n),
    .pll_locked_async (pll_locked_async),
    .clr_cnt          (clr_cnt),
    .pll_rst          (pll_rst),
    .chan_rst_n       (chan_rst_n),
    .all_ready        (all_ready),
    .timeout_err      (timeout_err),
    .lock_loss_cnt    (lock_loss_cnt),
    .sup_state        (sup_state)
  );

  typedef struct {
    int         adv;
    bit         locked;
    bit         clr;
    bit         pll_rst;
    logic [3:0] chan;
    bit         ready;
    logic [2:0] state;
    bit         to;
    int         cnt;
  } vec_t;

  vec_t vtab[16];

  // Loss counter reads zero when the feature is not built.
  function automatic int ec(input int full);
`ifdef PLL_SUP_LOSS_CNT_EN
    return full;
`else
    return 0 * full;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input bit pr, input logic [3:0] ch,
                         input bit rd, input logic [2:0] st, input bit to, input int cnt);
    chk({nm, ".pll_rst"}, idx, 32'(pll_rst), 32'(pr));
    chk({nm, ".chan"}, idx, 32'(chan_rst_n), 32'(ch));
    chk({nm, ".ready"}, idx, 32'(all_ready), 32'(rd));
    chk({nm, ".state"}, idx, 32'(sup_state), 32'(st));
    chk({nm, ".timeout"}, idx, 32'(timeout_err), 32'(to));
    chk({nm, ".cnt"}, idx, 32'(lock_loss_cnt), 32'(cnt));
    $display("[TB] %s %0d: state=%0d chan=%b ready=%0b pll_rst=%0b cnt=%0d",
             nm, idx, sup_state, chan_rst_n, all_ready, pll_rst, lock_loss_cnt);
  endtask

  task automatic wait_ready(input int bound, input int idx);
    int n = 0;
    while (all_ready !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    chk("wait_ready", idx, 32'(all_ready), 32'd1);
  endtask

  task automatic wait_chan(input logic [3:0] val, input int bound);
    int n = 0;
    while (chan_rst_n !== val && n < bound) begin
      tick(1);
      n++;
    end
    chk("wait_chan", 0, 32'(chan_rst_n), 32'(val));
  endtask

  task automatic do_reset(input bit lk);
    rst_n = 1'b0;
    pll_locked_async = lk;
    clr_cnt = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Nominal bring-up with lock high from cycle 0, ending in the first lock loss.
    //          adv lk clr pr chan   rd st  to cnt
    vtab[0]  = '{7, 1, 0, 1, 4'b0000, 0, 3'd0, 0, 0};
    vtab[1]  = '{1, 1, 0, 0, 4'b0000, 0, 3'd1, 0, 0};
    vtab[2]  = '{1, 1, 0, 0, 4'b0000, 0, 3'd2, 0, 0};
    vtab[3]  = '{15, 1, 0, 0, 4'b0000, 0, 3'd2, 0, 0};
    vtab[4]  = '{1, 1, 0, 0, 4'b0001, 0, 3'd3, 0, 0};
    vtab[5]  = '{3, 1, 0, 0, 4'b0001, 0, 3'd3, 0, 0};
    vtab[6]  = '{1, 1, 0, 0, 4'b0011, 0, 3'd3, 0, 0};
    vtab[7]  = '{3, 1, 0, 0, 4'b0011, 0, 3'd3, 0, 0};
    vtab[8]  = '{1, 1, 0, 0, 4'b0111, 0, 3'd3, 0, 0};
    vtab[9]  = '{3, 1, 0, 0, 4'b0111, 0, 3'd3, 0, 0};
    vtab[10] = '{1, 1, 0, 0, 4'b1111, 0, 3'd3, 0, 0};
    vtab[11] = '{3, 1, 0, 0, 4'b1111, 0, 3'd3, 0, 0};
    vtab[12] = '{1, 1, 0, 0, 4'b1111, 1, 3'd4, 0, 0};
    vtab[13] = '{9, 1, 0, 0, 4'b1111, 1, 3'd4, 0, 0};
    vtab[14] = '{2, 0, 0, 0, 4'b1111, 1, 3'd4, 0, 0};
    vtab[15] = '{1, 0, 0, 1, 4'b0000, 0, 3'd0, 0, 1};

    rst_n = 1'b0;
    pll_locked_async = 1'b1;
    clr_cnt = 1'b0;
    tick(2);
    chk_all("reset", 0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      pll_locked_async = vtab[i].locked;
      clr_cnt = vtab[i].clr;
      tick(vtab[i].adv);
      chk_all("nominal", i, vtab[i].pll_rst, vtab[i].chan, vtab[i].ready,
              vtab[i].state, vtab[i].to, ec(vtab[i].cnt));
    end

    // Repeated losses in RUN saturate the counter at 3.
    for (int k = 2; k <= 4; k++) begin
      pll_locked_async = 1'b1;
      wait_ready(300, k);
      pll_locked_async = 1'b0;
      tick(2);
      chk("loss_hold.ready", k, 32'(all_ready), 32'd1);
      tick(1);
      chk_all("loss", k, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, ec((k > 3) ? 3 : k));
    end

    // Clear coincident with a loss: count 3 becomes 1.
    pll_locked_async = 1'b1;
    wait_ready(300, 5);
    pll_locked_async = 1'b0;
    tick(2);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    chk_all("clr_loss", 0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, ec(1));

    // Reset asserted mid-release takes effect without a clock edge.
    pll_locked_async = 1'b1;
    wait_chan(4'b0011, 300);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_reset", 0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 0);

    // No lock: timeout every 8+64 cycles with a fresh 8-cycle reset pulse.
    do_reset(1'b0);
    begin
      int         edges[8]  = '{71, 72, 73, 79, 80, 143, 144, 145};
      bit         e_pr[8]   = '{0, 1, 1, 1, 0, 0, 1, 1};
      bit         e_to[8]   = '{0, 1, 0, 0, 0, 0, 1, 0};
      logic [2:0] e_st[8]   = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
      int         now = 0;
      for (int i = 0; i < 8; i++) begin
        tick(edges[i] - now);
        now = edges[i];
        chk_all("timeout", i, e_pr[i], 4'b0000, 1'b0, e_st[i], e_to[i], 0);
      end
    end

    // One-cycle dropout at stability count 10: back to WAIT_LOCK, count restarts.
    do_reset(1'b1);
    tick(17);
    pll_locked_async = 1'b0;
    tick(1);
    pll_locked_async = 1'b1;
    tick(1);
    chk_all("glitch", 0, 1'b0, 4'b0000, 1'b0, 3'd2, 1'b0, 0);
    tick(1);
    chk_all("glitch", 1, 1'b0, 4'b0000, 1'b0, 3'd1, 1'b0, 0);
    tick(1);
    chk_all("glitch", 2, 1'b0, 4'b0000, 1'b0, 3'd2, 1'b0, 0);
    tick(15);
    chk_all("glitch", 3, 1'b0, 4'b0000, 1'b0, 3'd2, 1'b0, 0);
    tick(1);
    chk_all("glitch", 4, 1'b0, 4'b0001, 1'b0, 3'd3, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
